sum_seq_ctrl: RTL and testbench
===============================

# sum_seq_ctrl

Sequencing controller that wraps the chunked serial adder (`sum_N1024_CC32`). It accepts two N-bit operands through a valid/ready handshake and drives them to the adder as CC chunks of W = N/CC bits, least significant chunk first. It clears the adder's carry register between operations, reassembles the W-bit sums into an N-bit result, and presents the result through a second valid/ready handshake. It sits upstream of the adder's a/b inputs and downstream of its c output.

## Interface
Parameters:
- N, 1024, operand/result width; N % CC == 0 is required (elaboration error otherwise)
- CC, 32, chunk count = adder cycles per operation; W = N/CC (32 by default)

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  controller can accept an operand pair
- in_a  in  N  operand A
- in_b  in  N  operand B
- add_a  out  W  chunk to adder input a
- add_b  out  W  chunk to adder input b
- add_rst  out  1  drives the adder's rst; clears its carry register at the next edge
- add_c  in  W  adder sum chunk c
- out_valid  out  1  result valid
- out_ready  in  1  result consumer ready
- out_sum  out  N  assembled sum modulo 2^N
- out_cout  out  1  final carry out (present only with SUM_SEQ_COUT_EN)

## Operation
- States: IDLE, RUN, DONE. Chunk counter k counts 0..CC-1 in RUN.
- IDLE:
  - in_ready = 1.
  - in_valid & in_ready at an edge: load the a/b shift registers, set k=0, go to RUN.
- RUN:
  - add_a and add_b are the low W bits of their shift registers, i.e. chunk k.
  - Each edge: both shift registers shift right by W. The result register shifts right by W with add_c entering at the top: r <= {add_c, r[N-1:W]}.
  - k increments each edge. The edge where k == CC-1 goes to DONE. After CC shifts, chunk 0 sits at r[W-1:0].
- DONE:
  - out_valid = 1 and out_sum = r, both held stable until out_valid & out_ready at an edge, which goes to IDLE.
  - in_ready = 0; in_valid is ignored.
- add_rst = rst | (state != RUN). The adder's carry is therefore zero on the first RUN cycle, and no carry leaks between operations.
- Arithmetic: out_sum = (in_a + in_b) mod 2^N. Carry out of the top chunk is discarded unless SUM_SEQ_COUT_EN is defined.

## Timing
- Latency: out_valid rises exactly CC edges after the accepting edge.
- Minimum initiation interval: CC+2 cycles (RUN, one DONE cycle, one IDLE cycle).
- in_ready and out_valid are decoded from registered state. out_ready has no combinational path to in_ready.
- Reset values (edge with rst=1):
  - state=IDLE, k=0, shift registers=0, out_sum=0, out_cout=0.
  - During the rst cycle: in_ready=0, out_valid=0, add_rst=1, add_a=add_b=0.
  - From the following cycle: in_ready=1.
- Reset mid-operation, in RUN or DONE: the operation is abandoned, no out_valid is produced, and the adder carry is cleared.
- in_valid held high across DONE: not accepted until the cycle after the handshake returns the controller to IDLE.

## Configuration
- SUM_SEQ_COUT_EN defined:
  - out_cout port exists.
  - The register captured on the last RUN edge holds (a_msb & b_msb) | ((a_msb ^ b_msb) & ~c_msb), where a_msb, b_msb and c_msb are bit W-1 of add_a, add_b and add_c. This equals the carry out of the adder's top chunk.
  - out_cout is valid together with out_sum.
- Not defined: no out_cout port and no carry logic; the result is modulo 2^N only.

## Structure
- Package sum_seq_pkg holds:
  - the state enum typedef (IDLE/RUN/DONE)
  - default N and CC constants
  - a function computing the counter width $clog2(CC)
- Sub-module sum_chunk_shreg (N-bit register, parallel load, W-bit right shift with W-bit top fill) is instantiated three times: operand A, operand B, result.
- The adder itself is instantiated alongside this block at the next level up, not inside it.

## Test plan
- in_a = 2^32-1, in_b = 1: out_sum = 2^32, out_cout = 0, out_valid rising exactly 32 edges after acceptance. Checks carry across the chunk 0→1 boundary.
- in_a = all ones, in_b = 1: out_sum = 0, out_cout = 1.
- Back-to-back: op1 all ones + 1, then op2 0 + 0: op2 sum = 0. Checks that add_rst cleared the carry.
- out_ready held low 5 cycles in DONE with in_valid = 1: out_sum stable, in_ready = 0, and the new operands are accepted only after the handshake plus one IDLE cycle.
- rst pulsed at k = 10: no out_valid, in_ready = 1 the next cycle, and the following op 3 + 5 yields 8.
- 200 random operand pairs with random out_ready stalls: every out_sum/out_cout matches the reference model.

Source files
------------

// File: rtl/sum_seq_pkg.sv
// Shared types and defaults for the chunked serial-adder sequencing controller.
package sum_seq_pkg;

    localparam int unsigned DEF_N  = 1024;
    localparam int unsigned DEF_CC = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Chunk counter width; at least one bit so CC == 1 still elaborates.
    function automatic int unsigned cnt_width(input int unsigned cc);
        return (cc > 1) ? $clog2(cc) : 1;
    endfunction

endpackage

// File: rtl/sum_chunk_shreg.sv
// N-bit register with parallel load and a W-bit right shift that fills the top chunk.
module sum_chunk_shreg
    import sum_seq_pkg::*;
#(
    parameter int unsigned N     = DEF_N,
    parameter int unsigned W     = DEF_N / DEF_CC,
    parameter int unsigned OUT_W = N
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [N-1:0]     load_data,
    input  logic [W-1:0]     fill,
    output logic [OUT_W-1:0] q
);

    logic [N-1:0] r;
    logic [N-1:0] shifted;

    if (N > W) begin : g_shift
        assign shifted = {fill, r[N-1:W]};
    end else begin : g_single
        assign shifted = fill;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r <= '0;
        end else if (load) begin
            r <= load_data;
        end else if (shift) begin
            r <= shifted;
        end
    end

    // Operand instances only expose the low chunk that feeds the adder.
    assign q = r[OUT_W-1:0];

endmodule

// File: rtl/sum_seq_ctrl.sv
// Feeds a chunked serial adder LSB-chunk first and reassembles the N-bit sum.
// Optional carry-out port and logic enabled by defining SUM_SEQ_COUT_EN.
module sum_seq_ctrl
    import sum_seq_pkg::*;
#(
    parameter int unsigned N  = DEF_N,
    parameter int unsigned CC = DEF_CC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    in_a,
    input  logic [N-1:0]    in_b,
    output logic [N/CC-1:0] add_a,
    output logic [N/CC-1:0] add_b,
    output logic            add_rst,
    input  logic [N/CC-1:0] add_c,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    out_sum
`ifdef SUM_SEQ_COUT_EN
   ,output logic            out_cout
`endif
);

    localparam int unsigned W  = N / CC;
    localparam int unsigned KW = cnt_width(CC);

    if (N % CC != 0) begin : g_cfg_check
        $error("sum_seq_ctrl: N must be a multiple of CC");
    end

    state_t        state;
    state_t        state_nxt;
    logic [KW-1:0] k;
    logic          run;
    logic          last;
    logic          accept;
    logic [W-1:0]  a_lo;
    logic [W-1:0]  b_lo;

    assign run    = (state == RUN);
    assign last   = run && (k == KW'(CC - 1));
    assign accept = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    if (out_valid && out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Reset forces the handshakes low and holds the adder carry cleared.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        add_rst   = 1'b1;
        add_a     = '0;
        add_b     = '0;
        if (!rst) begin
            in_ready  = (state == IDLE);
            out_valid = (state == DONE);
            add_rst   = !run;
            add_a     = a_lo;
            add_b     = b_lo;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || accept) begin
            k <= '0;
        end else if (run) begin
            k <= k + KW'(1);
        end
    end

    sum_chunk_shreg #(.N(N), .W(W), .OUT_W(W)) u_a_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .shift     (run),
        .load_data (in_a),
        .fill      ('0),
        .q         (a_lo)
    );

    sum_chunk_shreg #(.N(N), .W(W), .OUT_W(W)) u_b_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .shift     (run),
        .load_data (in_b),
        .fill      ('0),
        .q         (b_lo)
    );

    sum_chunk_shreg #(.N(N), .W(W), .OUT_W(N)) u_sum_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (1'b0),
        .shift     (run),
        .load_data ('0),
        .fill      (add_c),
        .q         (out_sum)
    );

`ifdef SUM_SEQ_COUT_EN
    // Carry out of the top chunk, recovered from its MSBs and the sum MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_cout <= 1'b0;
        end else if (last) begin
            out_cout <= (add_a[W-1] & add_b[W-1]) |
                        ((add_a[W-1] ^ add_b[W-1]) & ~add_c[W-1]);
        end
    end
`endif

endmodule

// File: tb/tb_sum_seq_ctrl.sv
// Bench for sum_seq_ctrl with a behavioural serial adder; carry-out checks
// are active when SUM_SEQ_COUT_EN is defined.
`timescale 1ns/1ps
module tb_sum_seq_ctrl;

    localparam int unsigned N  = 1024;
    localparam int unsigned CC = 32;
    localparam int unsigned W  = N / CC;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [N-1:0] in_a = '0;
    logic [N-1:0] in_b = '0;
    logic         in_ready;
    logic         out_valid;
    logic         add_rst;
    logic [N-1:0] out_sum;
    logic [W-1:0] add_a;
    logic [W-1:0] add_b;
    logic [W-1:0] add_c;
`ifdef SUM_SEQ_COUT_EN
    logic         out_cout;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Chunked adder environment: carry register cleared by add_rst.
    logic         carry_q;
    logic [W:0]   add_full;
    assign add_full = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, carry_q};
    assign add_c    = add_full[W-1:0];
    always @(posedge clk) carry_q <= add_rst ? 1'b0 : add_full[W];

    sum_seq_ctrl #(.N(N), .CC(CC)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_rst   (add_rst),
        .add_c     (add_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum)
`ifdef SUM_SEQ_COUT_EN
       ,.out_cout  (out_cout)
`endif
    );

    function automatic logic [N:0] ref_add(input logic [N-1:0] a, input logic [N-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    function automatic logic [N-1:0] rand_vec();
        logic [N-1:0] v;
        for (int i = 0; i < int'(N / 32); i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    function automatic int first_diff(input logic [N-1:0] x, input logic [N-1:0] y);
        for (int i = 0; i < int'(CC); i++) if (x[i*W +: W] !== y[i*W +: W]) return i;
        return 0;
    endfunction

    function automatic logic [W-1:0] chunk(input logic [N-1:0] v, input int i);
        return v[i*W +: W];
    endfunction

    // Present one operand pair at a falling edge; returns just after the accepting edge.
    task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b, output bit ok);
        int guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        ok = in_ready;
        if (!ok) return;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat, output bit ok);
        lat = 0;
        while (!out_valid && lat < int'(4 * CC)) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        ok = out_valid;
    endtask

    task automatic finish_op(input int stall, output logic [N-1:0] s, output logic co);
        out_ready = 1'b0;
        repeat (stall) begin
            @(posedge clk);
            @(negedge clk);
        end
        s = out_sum;
`ifdef SUM_SEQ_COUT_EN
        co = out_cout;
`else
        co = 1'b0;
`endif
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input int stall,
                         output logic [N-1:0] s, output logic co, output int lat, output bit ok);
        start_op(a, b, ok);
        lat = 0;
        s   = '0;
        co  = 1'b0;
        if (!ok) return;
        wait_result(lat, ok);
        if (!ok) return;
        finish_op(stall, s, co);
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (add_rst !== 1'b1) begin n_fail++; $display("FAIL rst_add_rst: got %b expected 1", add_rst); end
        n_checks++; if ({add_a, add_b} !== '0) begin n_fail++; $display("FAIL rst_add_ab: got %h/%h expected 0/0", add_a, add_b); end
        n_checks++; if (out_sum !== '0) begin n_fail++; $display("FAIL rst_out_sum: got chunk0 %h expected 0", chunk(out_sum, 0)); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_in_ready: got %b expected 1", in_ready); end
        n_checks++; if (add_rst !== 1'b1) begin n_fail++; $display("FAIL idle_add_rst: got %b expected 1", add_rst); end
    endtask

    task automatic test_chunk_carry();
        logic [N-1:0] a, b, s, e;
        logic co;
        int lat, d;
        bit ok;
        a = '0; a[31:0] = 32'hFFFF_FFFF;
        b = '0; b[0] = 1'b1;
        e = '0; e[32] = 1'b1;
        do_op(a, b, 0, s, co, lat, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL carry32_done: got timeout expected result"); end
        n_checks++; if (lat != int'(CC)) begin n_fail++; $display("FAIL carry32_latency: got %0d expected %0d", lat, CC); end
        d = first_diff(s, e);
        n_checks++; if (s !== e) begin n_fail++; $display("FAIL carry32_sum: chunk %0d got %h expected %h", d, chunk(s, d), chunk(e, d)); end
`ifdef SUM_SEQ_COUT_EN
        n_checks++; if (co !== 1'b0) begin n_fail++; $display("FAIL carry32_cout: got %b expected 0", co); end
`endif
    endtask

    task automatic test_overflow();
        logic [N-1:0] a, b, s;
        logic co;
        int lat, d;
        bit ok;
        a = '1;
        b = '0; b[0] = 1'b1;
        do_op(a, b, 1, s, co, lat, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL ovf_done: got timeout expected result"); end
        d = first_diff(s, '0);
        n_checks++; if (s !== '0) begin n_fail++; $display("FAIL ovf_sum: chunk %0d got %h expected 0", d, chunk(s, d)); end
`ifdef SUM_SEQ_COUT_EN
        n_checks++; if (co !== 1'b1) begin n_fail++; $display("FAIL ovf_cout: got %b expected 1", co); end
`endif
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] a, b, s;
        logic co;
        int lat, d;
        bit ok;
        a = '1;
        b = '0; b[0] = 1'b1;
        do_op(a, b, 0, s, co, lat, ok);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_idle_ready: got %b expected 1", in_ready); end
        do_op('0, '0, 0, s, co, lat, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_done: got timeout expected result"); end
        d = first_diff(s, '0);
        n_checks++; if (s !== '0) begin n_fail++; $display("FAIL b2b_sum: chunk %0d got %h expected 0", d, chunk(s, d)); end
`ifdef SUM_SEQ_COUT_EN
        n_checks++; if (co !== 1'b0) begin n_fail++; $display("FAIL b2b_cout: got %b expected 0", co); end
`endif
    endtask

    task automatic test_stall();
        logic [N-1:0] a1, b1, a2, b2, s, e1, e2;
        logic [N:0] r;
        logic co;
        int lat, d;
        bit ok;
        a1 = rand_vec(); b1 = rand_vec();
        a2 = rand_vec(); b2 = rand_vec();
        r = ref_add(a1, b1); e1 = r[N-1:0];
        r = ref_add(a2, b2); e2 = r[N-1:0];
        start_op(a1, b1, ok);
        if (ok) wait_result(lat, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL stall_first_done: got timeout expected result"); end
        in_valid = 1'b1;
        in_a = a2;
        in_b = b2;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid cyc %0d: got %b expected 1", i, out_valid); end
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready cyc %0d: got %b expected 0", i, in_ready); end
            d = first_diff(out_sum, e1);
            n_checks++; if (out_sum !== e1) begin n_fail++; $display("FAIL stall_sum cyc %0d: chunk %0d got %h expected %h", i, d, chunk(out_sum, d), chunk(e1, d)); end
            @(posedge clk);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++; if ({in_ready, add_rst} !== 2'b11) begin n_fail++; $display("FAIL stall_idle_gap: got ready/add_rst %b%b expected 11", in_ready, add_rst); end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++; if (add_rst !== 1'b0) begin n_fail++; $display("FAIL stall_accept_run: got add_rst %b expected 0", add_rst); end
        wait_result(lat, ok);
        n_checks++; if (lat != int'(CC)) begin n_fail++; $display("FAIL stall_second_latency: got %0d expected %0d", lat, CC); end
        finish_op(0, s, co);
        d = first_diff(s, e2);
        n_checks++; if (s !== e2) begin n_fail++; $display("FAIL stall_second_sum: chunk %0d got %h expected %h", d, chunk(s, d), chunk(e2, d)); end
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] a, b, s, e;
        logic co;
        int lat, d;
        bit ok, seen;
        a = '1;
        b = '0; b[0] = 1'b1;
        start_op(a, b, ok);
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        n_checks++; if ({add_rst, in_ready, out_valid} !== 3'b100) begin n_fail++; $display("FAIL midrst_outputs: got add_rst/ready/valid %b%b%b expected 100", add_rst, in_ready, out_valid); end
        n_checks++; if ({add_a, add_b} !== '0) begin n_fail++; $display("FAIL midrst_add_ab: got %h/%h expected 0/0", add_a, add_b); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b expected 1", in_ready); end
        seen = 1'b0;
        repeat (2 * CC) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        n_checks++; if (seen) begin n_fail++; $display("FAIL midrst_no_valid: got out_valid 1 expected 0"); end
        a = '0; a[1:0] = 2'd3;
        b = '0; b[2:0] = 3'd5;
        e = '0; e[3:0] = 4'd8;
        do_op(a, b, 0, s, co, lat, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL midrst_next_done: got timeout expected result"); end
        d = first_diff(s, e);
        n_checks++; if (s !== e) begin n_fail++; $display("FAIL midrst_next_sum: chunk %0d got %h expected %h", d, chunk(s, d), chunk(e, d)); end
    endtask

    task automatic test_random();
        logic [N-1:0] a, b, s, e;
        logic [N:0] r;
        logic co;
        int lat, d, sel;
        bit ok;
        for (int t = 0; t < 200; t++) begin
            a = rand_vec();
            b = rand_vec();
            sel = int'($urandom_range(0, 7));
            if (sel == 0) b = ~a;
            if (sel == 1) begin a = '1; b[N-1:W] = '0; end
            if (sel == 2) b = '0;
            r = ref_add(a, b);
            e = r[N-1:0];
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_op(a, b, int'($urandom_range(0, 3)), s, co, lat, ok);
            n_checks++; if (!ok || lat != int'(CC)) begin n_fail++; $display("FAIL rand_latency op %0d: got %0d ok %b expected %0d", t, lat, ok, CC); end
            d = first_diff(s, e);
            n_checks++; if (s !== e) begin n_fail++; $display("FAIL rand_sum op %0d: chunk %0d got %h expected %h", t, d, chunk(s, d), chunk(e, d)); end
`ifdef SUM_SEQ_COUT_EN
            n_checks++; if (co !== r[N]) begin n_fail++; $display("FAIL rand_cout op %0d: got %b expected %b", t, co, r[N]); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_chunk_carry();
        test_overflow();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
